cmd_dispatcher: RTL and testbench
=================================

# cmd_dispatcher

Parametrised successor to the RX command parser. It pops instruction words from the RX command FIFO and write payload words from the RX data FIFO, then delivers each transaction to exactly one of `MODULES_CNT` downstream modules over a valid/ready handshake. It adds multi-word write bursts, address-error detection with payload draining, and an error counter. It sits between the RX FIFOs and the module register banks.

## Interface
- `FIFO_DATA_WIDTH`, 32: data FIFO word width and module data bus width.
- `FIFO_CMD_WIDTH`, 32: command word width; must be ≥ 1+`MODULE_SELECT_WIDTH`+`CMD_OUTPUT_WIDTH`+`LEN_WIDTH`.
- `CMD_OUTPUT_WIDTH`, 5: command field width.
- `MODULE_SELECT_WIDTH`, 5: module address width.
- `LEN_WIDTH`, 4: burst length field width; beats = LEN+1.
- `MODULES_CNT`, 19: number of targets, addressed 1..`MODULES_CNT`; 0 is invalid.
- `ERR_CNT_WIDTH`, 8: error counter width.
- `TIMEOUT_CYCLES`, 1024: handshake timeout; used only with the macro.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_cmd`  in  `FIFO_CMD_WIDTH`  FWFT command word. Bit 0 is RW (1 = write). Then MODULE_SELECT, then COMMAND, then LEN.
- `i_cmd_valid`  in  1  command FIFO not empty.
- `o_cmd_rd_en`  out  1  command pop strobe.
- `i_data`  in  `FIFO_DATA_WIDTH`  FWFT payload word.
- `i_data_valid`  in  1  data FIFO not empty.
- `o_data_rd_en`  out  1  data pop strobe.
- `o_mod_valid`  out  `MODULES_CNT`  one-hot valid; bit k targets module k+1.
- `i_mod_ready`  in  `MODULES_CNT`  per-module ready.
- `o_mod_write`  out  1  shared: transaction is a write.
- `o_mod_cmd`  out  `CMD_OUTPUT_WIDTH`  shared command field.
- `o_mod_data`  out  `FIFO_DATA_WIDTH`  shared payload; 0 on reads.
- `o_mod_last`  out  1  final beat of the transaction.
- `o_busy`  out  1  FSM not in IDLE.
- `o_err_addr`  out  1  one-cycle pulse on an invalid address.
- `o_err_cnt`  out  `ERR_CNT_WIDTH`  saturating count of all errors.

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN.
- IDLE:
  - `o_cmd_rd_en = i_cmd_valid`, combinational.
  - On pop, latch RW, select, command, and beat counter = LEN+1.
  - Select 0 or > `MODULES_CNT`: pulse `o_err_addr` and increment `o_err_cnt`. A write goes to DRAIN; a read stays in IDLE.
  - Valid read: go to ISSUE with data = 0, beats = 1, LEN ignored.
  - Valid write: go to LOAD.
- LOAD:
  - `o_data_rd_en = i_data_valid`.
  - On pop, register `i_data`, decrement the beat counter, and go to ISSUE. Without data, wait in LOAD.
- ISSUE:
  - Hold the selected `o_mod_valid` bit and all shared fields stable until `i_mod_ready` of that module is 1.
  - `o_mod_last` = 1 when the beat counter is 0.
  - On handshake: last beat → IDLE, otherwise → LOAD.
- DRAIN:
  - Pop `i_data` while valid, counting down the beat counter.
  - On the final pop, return to IDLE. Drained data reaches no module.
- Only one `o_mod_valid` bit is ever high. `o_cmd_rd_en` and `o_data_rd_en` are never high in the same cycle.
- `o_err_cnt` saturates at all ones.
- Reset, including mid-transaction:
  - State → IDLE.
  - All outputs 0 and `o_err_cnt` = 0.
  - No pop strobes; the partial transaction is abandoned.

## Timing
- Read latency: command popped in cycle N, `o_mod_valid` high from cycle N+1.
- Write latency: command popped in N, first data popped in N+1 (if valid), `o_mod_valid` high from N+2.
- Each write beat takes ≥ 2 cycles (LOAD + ISSUE); a read takes ≥ 2 cycles including IDLE.
- Ready held high: a burst of LEN+1 beats completes in 1+2·(LEN+1) cycles.
- All outputs except the two pop strobes are registered.

## Configuration
- `CMD_DISPATCHER_TIMEOUT_EN` defined:
  - A counter runs in ISSUE. After `TIMEOUT_CYCLES` cycles without a handshake, the FSM drops `o_mod_valid` and increments `o_err_cnt`.
  - If write beats remain, it goes to DRAIN for the rest; otherwise it goes to IDLE.
- Macro undefined: ISSUE waits indefinitely and the counter logic is absent.

## Structure
- Package `cmd_dispatcher_pkg` holds:
  - the state enum;
  - localparam bit offsets of the RW, MODULE_SELECT, COMMAND and LEN fields;
  - a decode function returning a packed command struct.
- Natural sub-module: `sat_counter`, a parametrised saturating error counter, reusable elsewhere.

## Test plan
- Read, select=3, cmd=5, `i_mod_ready[2]`=1 → `o_mod_valid`=0x4 for 1 cycle at N+1; `o_mod_write`=0, `o_mod_last`=1, data=0.
- Write burst, select=1, LEN=2, data 0xA,0xB,0xC, ready high → three beats on bit 0 with data A,B,C; `o_mod_last` only on C; three `o_data_rd_en` pulses.
- Write, select=2, ready held low 10 cycles → valid and data stable for 10 cycles; handshake on cycle 11; then IDLE.
- Write, select=0, LEN=1 → `o_err_addr` pulse; 2 data words drained; no `o_mod_valid`; `o_err_cnt`=1.
- Assert `rst` mid-burst after 1 of 3 beats → all outputs 0 immediately; IDLE; next command is processed normally.
- With `CMD_DISPATCHER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, ready never asserted → valid drops after 16 cycles; `o_err_cnt` +1; remaining beats drained.

Source files
------------

// File: rtl/cmd_dispatcher_pkg.sv
// cmd_dispatcher shared types: FSM states, command field offsets
// and the command-word decoder.
package cmd_dispatcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN
    } state_t;

    localparam int RW_OFF     = 0;
    localparam int SEL_OFF    = 1;
    localparam int SEL_W_DFLT = 5;
    localparam int CMD_W_DFLT = 5;
    localparam int LEN_W_DFLT = 4;

    // Fields are held at full width; callers slice to their own widths.
    typedef struct packed {
        logic        rw;
        logic [31:0] sel;
        logic [31:0] cmd;
        logic [31:0] len;
    } cmd_fields_t;

    function automatic int cmd_off(input int sel_w);
        return SEL_OFF + sel_w;
    endfunction

    function automatic int len_off(input int sel_w, input int cmd_w);
        return SEL_OFF + sel_w + cmd_w;
    endfunction

    function automatic logic [63:0] field_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic cmd_fields_t decode(
        input logic [63:0] word,
        input int          sel_w,
        input int          cmd_w,
        input int          len_w
    );
        cmd_fields_t f;
        f.rw  = word[RW_OFF];
        f.sel = 32'((word >> SEL_OFF) & field_mask(sel_w));
        f.cmd = 32'((word >> cmd_off(sel_w)) & field_mask(cmd_w));
        f.len = 32'((word >> len_off(sel_w, cmd_w)) & field_mask(len_w));
        return f;
    endfunction

endpackage

// File: rtl/cmd_dispatcher_sat.sv
// sat_counter: saturating up-counter with async active-high reset,
// used for error tallies.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: routes RX FIFO commands and write bursts to one of
// MODULES_CNT targets. Optional: CMD_DISPATCHER_TIMEOUT_EN.
module cmd_dispatcher
    import cmd_dispatcher_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH     = 32,
    parameter int FIFO_CMD_WIDTH      = 32,
    parameter int CMD_OUTPUT_WIDTH    = CMD_W_DFLT,
    parameter int MODULE_SELECT_WIDTH = SEL_W_DFLT,
    parameter int LEN_WIDTH           = LEN_W_DFLT,
    parameter int MODULES_CNT         = 19,
    parameter int ERR_CNT_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FIFO_CMD_WIDTH-1:0]   i_cmd,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0]  i_data,
    input  logic                        i_data_valid,
    output logic                        o_data_rd_en,
    output logic [MODULES_CNT-1:0]      o_mod_valid,
    input  logic [MODULES_CNT-1:0]      i_mod_ready,
    output logic                        o_mod_write,
    output logic [CMD_OUTPUT_WIDTH-1:0] o_mod_cmd,
    output logic [FIFO_DATA_WIDTH-1:0]  o_mod_data,
    output logic                        o_mod_last,
    output logic                        o_busy,
    output logic                        o_err_addr,
    output logic [ERR_CNT_WIDTH-1:0]    o_err_cnt
);

    localparam int CNT_W = LEN_WIDTH + 1;
    localparam int MSW   = MODULE_SELECT_WIDTH;

    state_t            state;
    cmd_fields_t       dec;
    logic [MSW-1:0]    sel_now;
    logic [MSW-1:0]    sel_q;
    logic [CNT_W-1:0]  beats_now;
    logic [CNT_W-1:0]  beats;
    logic              sel_ok;
    logic              handshake;
    logic              timeout;
    logic              err_inc;

    function automatic logic [MODULES_CNT-1:0] onehot(
        input logic [MSW-1:0] s
    );
        return MODULES_CNT'(1) << (s - MSW'(1));
    endfunction

    assign dec = decode(64'(i_cmd), MSW,
                        CMD_OUTPUT_WIDTH, LEN_WIDTH);

    assign sel_now   = dec.sel[MSW-1:0];
    assign beats_now = {1'b0, dec.len[LEN_WIDTH-1:0]} + CNT_W'(1);
    assign sel_ok    = dec.sel != 32'd0 &&
                       dec.sel <= 32'(MODULES_CNT);

    // Strobes are combinational, so they are gated during reset.
    assign o_cmd_rd_en  = !rst && state == IDLE && i_cmd_valid;
    assign o_data_rd_en = !rst && i_data_valid &&
                          (state == LOAD || state == DRAIN);

    assign handshake = state == ISSUE &&
                       |(o_mod_valid & i_mod_ready);
    assign err_inc   = (o_cmd_rd_en && !sel_ok) || timeout;

`ifdef CMD_DISPATCHER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign timeout = state == ISSUE && !handshake &&
                     tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE && !handshake && !timeout) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    sat_counter #(
        .WIDTH (ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (o_err_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_q       <= '0;
            beats       <= '0;
            o_mod_valid <= '0;
            o_mod_write <= 1'b0;
            o_mod_cmd   <= '0;
            o_mod_data  <= '0;
            o_mod_last  <= 1'b0;
            o_busy      <= 1'b0;
            o_err_addr  <= 1'b0;
        end else begin
            o_err_addr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (o_cmd_rd_en) begin
                        sel_q       <= sel_now;
                        o_mod_write <= dec.rw;
                        o_mod_cmd   <= dec.cmd[CMD_OUTPUT_WIDTH-1:0];
                        if (!sel_ok) begin
                            o_err_addr <= 1'b1;
                            if (dec.rw) begin
                                beats  <= beats_now;
                                state  <= DRAIN;
                                o_busy <= 1'b1;
                            end
                        end else if (dec.rw) begin
                            beats  <= beats_now;
                            state  <= LOAD;
                            o_busy <= 1'b1;
                        end else begin
                            beats       <= '0;
                            o_mod_data  <= '0;
                            o_mod_last  <= 1'b1;
                            o_mod_valid <= onehot(sel_now);
                            state       <= ISSUE;
                            o_busy      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (o_data_rd_en) begin
                        o_mod_data  <= i_data;
                        beats       <= beats - CNT_W'(1);
                        o_mod_last  <= beats == CNT_W'(1);
                        o_mod_valid <= onehot(sel_q);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        o_mod_valid <= '0;
                        o_mod_last  <= 1'b0;
                        if (beats == '0) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (timeout) begin
                        o_mod_valid <= '0;
                        o_mod_last  <= 1'b0;
                        if (beats != '0) begin
                            state <= DRAIN;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (o_data_rd_en) begin
                        beats <= beats - CNT_W'(1);
                        if (beats == CNT_W'(1)) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher: directed cases then random
// traffic against a transaction-level model.
module tb_cmd_dispatcher;

    localparam int DW = 32;
    localparam int CW = 32;
    localparam int OW = 5;
    localparam int SW = 5;
    localparam int LW = 4;
    localparam int MC = 19;
    localparam int EW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] i_cmd;
    logic          i_cmd_valid;
    logic          o_cmd_rd_en;
    logic [DW-1:0] i_data;
    logic          i_data_valid;
    logic          o_data_rd_en;
    logic [MC-1:0] o_mod_valid;
    logic [MC-1:0] i_mod_ready;
    logic          o_mod_write;
    logic [OW-1:0] o_mod_cmd;
    logic [DW-1:0] o_mod_data;
    logic          o_mod_last;
    logic          o_busy;
    logic          o_err_addr;
    logic [EW-1:0] o_err_cnt;

    cmd_dispatcher #(
        .FIFO_DATA_WIDTH     (DW),
        .FIFO_CMD_WIDTH      (CW),
        .CMD_OUTPUT_WIDTH    (OW),
        .MODULE_SELECT_WIDTH (SW),
        .LEN_WIDTH           (LW),
        .MODULES_CNT         (MC),
        .ERR_CNT_WIDTH       (EW),
        .TIMEOUT_CYCLES      (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd        (i_cmd),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_rd_en  (o_cmd_rd_en),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_rd_en (o_data_rd_en),
        .o_mod_valid  (o_mod_valid),
        .i_mod_ready  (i_mod_ready),
        .o_mod_write  (o_mod_write),
        .o_mod_cmd    (o_mod_cmd),
        .o_mod_data   (o_mod_data),
        .o_mod_last   (o_mod_last),
        .o_busy       (o_busy),
        .o_err_addr   (o_err_addr),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          mod;
        bit          wr;
        int          cmd;
        logic [31:0] data;
        bit          last;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cmd_q[$];
    logic [31:0] data_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int exp_err = 0;
    int exp_pulses = 0;
    int err_pulses = 0;
    int data_pops = 0;
    bit pend_c = 0;
    bit pend_d = 0;
    bit data_gap = 0;
    bit rand_ready = 0;
    logic [MC-1:0] ready_fix = '1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h need 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(bit rw, int sel, int c, int len);
        return 32'(rw) | (32'(sel & 31) << 1) |
               (32'(c & 31) << 6) | (32'(len & 15) << 11);
    endfunction

    function automatic int sat(int n);
        return n > 255 ? 255 : n;
    endfunction

    // Reference model: a command expands into the beats it must produce.
    task automatic send(bit rw, int sel, int c, int len, bit fixed,
                        logic [31:0] base, bit use_lat, int lat_add);
        exp_t e;
        logic [31:0] d;
        cmd_q.push_back(mk(rw, sel, c, len));
        if (sel < 1 || sel > MC) begin
            exp_err++;
            exp_pulses++;
            if (rw)
                for (int b = 0; b <= len; b++)
                    data_q.push_back($urandom);
        end else if (!rw) begin
            e = '{sel, 1'b0, c, 32'h0, 1'b1, use_lat ? 1 + lat_add : -1};
            exp_q.push_back(e);
        end else begin
            for (int b = 0; b <= len; b++) begin
                d = fixed ? base + 32'(b) : $urandom;
                data_q.push_back(d);
                e = '{sel, 1'b1, c, d, b == len,
                      use_lat ? 2 * (b + 1) + lat_add : -1};
                exp_q.push_back(e);
            end
        end
    endtask

    // FIFO / ready driver: inputs change 1 time unit after posedge.
    initial begin
        i_cmd = '0;
        i_cmd_valid = 1'b0;
        i_data = '0;
        i_data_valid = 1'b0;
        i_mod_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            if (pend_c && cmd_q.size() > 0) void'(cmd_q.pop_front());
            if (pend_d && data_q.size() > 0) void'(data_q.pop_front());
            pend_c = 0;
            pend_d = 0;
            i_cmd_valid = cmd_q.size() > 0;
            i_cmd = i_cmd_valid ? cmd_q[0] : 32'h0;
            i_data_valid = data_q.size() > 0 &&
                           !(data_gap && $urandom_range(0, 2) == 0);
            i_data = data_q.size() > 0 ? data_q[0] : 32'h0;
            i_mod_ready = rand_ready ? MC'($urandom) : ready_fix;
        end
    end

    // Monitor: samples at negedge, pops the scoreboard on each handshake.
    logic [57:0] prev;
    bit hold = 0;
    initial begin
        exp_t e;
        logic [MC-1:0] ev;
        bit hs;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_c = 0;
                pend_d = 0;
                hold = 0;
            end else begin
                pend_c = o_cmd_rd_en;
                pend_d = o_data_rd_en;
                if (o_cmd_rd_en) pop_cyc = cyc;
                if (o_data_rd_en) data_pops++;
                if (o_err_addr) err_pulses++;
                check("pop_excl", 64'(o_cmd_rd_en & o_data_rd_en), 0);
                check("onehot", 64'($countones(o_mod_valid) > 1), 0);
                if (hold) begin
`ifdef CMD_DISPATCHER_TIMEOUT_EN
                    if (o_mod_valid != '0)
`endif
                    check("stable", 64'({o_mod_valid, o_mod_write,
                          o_mod_cmd, o_mod_data, o_mod_last}),
                          64'(prev));
                end
                hs = |(o_mod_valid & i_mod_ready);
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(o_mod_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        ev = MC'(1) << (e.mod - 1);
                        check("beat_valid", 64'(o_mod_valid), 64'(ev));
                        check("beat_write", 64'(o_mod_write), 64'(e.wr));
                        check("beat_cmd", 64'(o_mod_cmd), 64'(e.cmd));
                        check("beat_data", 64'(o_mod_data), 64'(e.data));
                        check("beat_last", 64'(o_mod_last), 64'(e.last));
                        if (e.lat >= 0)
                            check("beat_latency", 64'(cyc - pop_cyc),
                                  64'(e.lat));
                    end
                end
                hold = o_mod_valid != '0 && !hs;
                prev = {o_mod_valid, o_mod_write, o_mod_cmd,
                        o_mod_data, o_mod_last};
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_q.size() == 0 &&
                data_q.size() == 0 && !o_busy)
                done = 1;
        end
        @(negedge clk);
        #1;
        check({"drain_", name}, 64'(done), 1);
    endtask

    task automatic check_errs(input string name);
        check({name, "_err_cnt"}, 64'(o_err_cnt), 64'(sat(exp_err)));
        check({name, "_err_pulses"}, 64'(err_pulses), 64'(exp_pulses));
    endtask

    initial begin
        int n;
        bit seen;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({o_mod_valid, o_mod_write, o_mod_last,
              o_busy, o_err_addr, o_cmd_rd_en, o_data_rd_en}), 0);
        check("reset_bus", 64'({o_mod_cmd, o_mod_data, o_err_cnt}), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        send(0, 3, 5, 0, 0, 0, 1, 0);
        wait_drain("read", 50);

        data_pops = 0;
        send(1, 1, 9, 2, 1, 32'hA, 1, 0);
        wait_drain("burst", 50);
        check("burst_pops", 64'(data_pops), 3);

        ready_fix = ~(MC'(1) << 1);
        send(1, 2, 7, 0, 1, 32'h55, 1, 10);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = o_mod_valid[1];
        end
        check("stall_valid_seen", 64'(seen), 1);
        repeat (9) @(negedge clk);
        ready_fix = '1;
        wait_drain("stall", 50);

        data_pops = 0;
        send(1, 0, 4, 1, 0, 0, 0, 0);
        wait_drain("bad_write", 50);
        check("bad_write_pops", 64'(data_pops), 2);
        check_errs("bad_write");

        send(1, 1, 12, 2, 1, 32'h100, 1, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = exp_q.size() == 2;
        end
        check("midburst_reached", 64'(seen), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_ctrl", 64'({o_mod_valid, o_mod_write, o_mod_last,
              o_busy, o_err_addr, o_cmd_rd_en, o_data_rd_en}), 0);
        check("rst_bus", 64'({o_mod_cmd, o_mod_data, o_err_cnt}), 0);
        cmd_q.delete();
        data_q.delete();
        exp_q.delete();
        exp_err = 0;
        exp_pulses = 0;
        err_pulses = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        send(0, MC, 17, 3, 0, 0, 1, 0);
        send(0, MC + 1, 2, 0, 0, 0, 0, 0);
        wait_drain("post_reset", 50);
        check_errs("post_reset");

`ifdef CMD_DISPATCHER_TIMEOUT_EN
        ready_fix = ~(MC'(1) << 3);
        cmd_q.push_back(mk(1, 4, 3, 2));
        for (int b = 0; b < 3; b++) data_q.push_back($urandom);
        exp_err++;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = o_mod_valid[3];
        end
        n = 0;
        while (o_mod_valid[3] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", 64'(n), 64'(TO));
        ready_fix = '1;
        wait_drain("timeout", 100);
        check("timeout_err_cnt", 64'(o_err_cnt), 64'(sat(exp_err)));
`endif

        rand_ready = 1;
        data_gap = 1;
        for (int k = 0; k < 150; k++)
            send($urandom_range(0, 1), $urandom_range(0, 22),
                 $urandom_range(0, 31), $urandom_range(0, 3),
                 0, 0, 0, 0);
        wait_drain("random", 20000);
        check_errs("random");

        rand_ready = 0;
        data_gap = 0;
        for (int k = 0; k < 300; k++)
            send(0, $urandom_range(MC + 1, 31), k, 0, 0, 0, 0, 0);
        wait_drain("saturate", 2000);
        n = exp_err;
        check("sat_err_cnt", 64'(o_err_cnt), 64'(sat(n)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
